// File: rtl/cpu_cfg_arb_if.sv
// Requester and APB signal bundle for cpu_cfg_arb.
// The arbiter keeps flat ports; this interface groups the same signals for
// the environment that drives requesters and models the register block.
interface cpu_cfg_arb_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*32-1:0] addr;
  logic [NUM_REQ*32-1:0] wdata;
  logic [NUM_REQ-1:0]    ack;
  logic [31:0]           rdata;
  logic                  err;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           paddr;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;

  // Requesters plus register block: drive requests and read data.
  modport master (
    output req, we, addr, wdata, prdata,
    input  ack, rdata, err, penable, pwrite, paddr, pwdata
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata, prdata,
    output ack, rdata, err, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/cpu_cfg_arb.sv
// Round-robin arbiter sharing one zero-wait-state APB config port between
// NUM_REQ valid/ready requesters. Out-of-window addresses complete with an
// error and never reach the APB port.
module cpu_cfg_arb #(
  parameter int NUM_REQ  = 2,
  parameter int NUM_REGS = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ-1:0]    i_we,
  input  logic [NUM_REQ*32-1:0] i_addr,
  input  logic [NUM_REQ*32-1:0] i_wdata,
  output logic [NUM_REQ-1:0]    o_ack,
  output logic [31:0]           o_rdata,
  output logic                  o_err,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [31:0]           o_paddr,
  output logic [31:0]           o_pwdata,
  input  logic [31:0]           i_prdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;

  logic [IW-1:0]      pick;
  logic [IW-1:0]      cand;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] win_oh;
  logic               any_req;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic               sel_legal;

  // Round-robin winner search from last+1; scanning downward lets the
  // nearest requester after last overwrite any farther one.
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = |i_req;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      cand = IW'((32'(last) + i) % 32'(NUM_REQ));
      if (i_req[cand]) pick = cand;
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    win_oh        = '0;
    win_oh[win]   = 1'b1;
    sel_we        = i_we[pick];
    sel_addr      = i_addr[32*pick +: 32];
    sel_wdata     = i_wdata[32*pick +: 32];
    sel_legal     = (int'(sel_addr[7:2]) < NUM_REGS);
  end

  // Sequencer: grant, APB setup/access, one-cycle response. The APB address,
  // data and direction registers double as the latched request fields.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      last      <= IW'(NUM_REQ - 1);
      win       <= '0;
      o_ack     <= '0;
      o_rdata   <= '0;
      o_err     <= 1'b0;
      o_penable <= 1'b0;
      o_pwrite  <= 1'b0;
      o_paddr   <= '0;
      o_pwdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last <= pick;
            win  <= pick;
            if (sel_legal) begin
              o_paddr   <= sel_addr;
              o_pwdata  <= sel_wdata;
              o_pwrite  <= sel_we;
              o_penable <= 1'b0;
              state     <= SETUP;
            end else begin
              o_ack   <= pick_oh;
              o_err   <= 1'b1;
              o_rdata <= '0;
              state   <= RESP;
            end
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          o_rdata   <= o_pwrite ? '0 : i_prdata;
          o_err     <= 1'b0;
          o_penable <= 1'b0;
          o_pwrite  <= 1'b0;
          o_ack     <= win_oh;
          state     <= RESP;
        end
        RESP: begin
          o_ack <= '0;
          o_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_cfg_arb.sv
// Directed bench for cpu_cfg_arb: a 2-requester instance against a small
// register-file model, plus a 4-requester instance for round-robin order.
module tb_cpu_cfg_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int order [6] = '{3, 0, 2, 3, 0, 2};

  cpu_cfg_arb_if #(.NUM_REQ(2)) b2 ();
  cpu_cfg_arb_if #(.NUM_REQ(4)) b4 ();

  cpu_cfg_arb #(.NUM_REQ(2), .NUM_REGS(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(b2.req), .i_we(b2.we), .i_addr(b2.addr), .i_wdata(b2.wdata),
    .o_ack(b2.ack), .o_rdata(b2.rdata), .o_err(b2.err),
    .o_penable(b2.penable), .o_pwrite(b2.pwrite),
    .o_paddr(b2.paddr), .o_pwdata(b2.pwdata), .i_prdata(b2.prdata)
  );

  cpu_cfg_arb #(.NUM_REQ(4), .NUM_REGS(6)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(b4.req), .i_we(b4.we), .i_addr(b4.addr), .i_wdata(b4.wdata),
    .o_ack(b4.ack), .o_rdata(b4.rdata), .o_err(b4.err),
    .o_penable(b4.penable), .o_pwrite(b4.pwrite),
    .o_paddr(b4.paddr), .o_pwdata(b4.pwdata), .i_prdata(b4.prdata)
  );

  // Register block model: six words, combinational read, write on access.
  logic [31:0] regs [6];
  logic [5:0]  idx2;
  assign idx2      = b2.paddr[7:2];
  assign b2.prdata = (idx2 < 6'd6) ? regs[idx2[2:0]] : '0;
  assign b4.prdata = 32'hA000_0000 | b4.paddr;

  always @(posedge clk) begin
    if (!rst_n) begin
      regs[0] <= '0;
      regs[1] <= '0;
      regs[2] <= 32'h2222_0002;
      regs[3] <= 32'd50000;
      regs[4] <= '0;
      regs[5] <= '0;
    end else if (b2.penable && b2.pwrite && idx2 < 6'd6) begin
      regs[idx2[2:0]] <= b2.pwdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b2.req = '0; b2.we = '0; b2.addr = '0; b2.wdata = '0;
    b4.req = '0; b4.we = '0; b4.addr = '0; b4.wdata = '0;
    tick; tick;
    chk("rst_ack",     32'(b2.ack), 32'h0);
    chk("rst_rdata",   b2.rdata, 32'h0);
    chk("rst_err",     32'(b2.err), 32'h0);
    chk("rst_penable", 32'(b2.penable), 32'h0);
    chk("rst_pwrite",  32'(b2.pwrite), 32'h0);
    chk("rst_paddr",   b2.paddr, 32'h0);
    chk("rst_pwdata",  b2.pwdata, 32'h0);
    chk("rst_ack4",    32'(b4.ack), 32'h0);
    rst_n = 1'b1;

    // req0 writes 0x1000 to 0x04
    b2.we = 2'b01; b2.addr[31:0] = 32'h4; b2.wdata[31:0] = 32'h1000; b2.req = 2'b01;
    tick;
    chk("wr_setup_penable", 32'(b2.penable), 32'h0);
    chk("wr_setup_pwrite",  32'(b2.pwrite), 32'h1);
    chk("wr_setup_paddr",   b2.paddr, 32'h4);
    chk("wr_setup_pwdata",  b2.pwdata, 32'h1000);
    tick;
    chk("wr_access_penable", 32'(b2.penable), 32'h1);
    chk("wr_access_paddr",   b2.paddr, 32'h4);
    chk("wr_access_ack",     32'(b2.ack), 32'h0);
    tick;
    chk("wr_resp_ack",     32'(b2.ack), 32'h1);
    chk("wr_resp_err",     32'(b2.err), 32'h0);
    chk("wr_resp_penable", 32'(b2.penable), 32'h0);
    b2.req = 2'b00;
    tick;
    chk("wr_idle_ack", 32'(b2.ack), 32'h0);

    // req1 reads 0x04 back
    b2.we = 2'b00; b2.addr[63:32] = 32'h4; b2.req = 2'b10;
    tick;
    chk("rd_setup_pwrite", 32'(b2.pwrite), 32'h0);
    chk("rd_setup_paddr",  b2.paddr, 32'h4);
    tick; tick;
    chk("rd_resp_ack",   32'(b2.ack), 32'h2);
    chk("rd_resp_rdata", b2.rdata, 32'h1000);
    chk("rd_resp_err",   32'(b2.err), 32'h0);
    b2.req = 2'b00;
    tick;

    // both requesters read 0x0C continuously: grants alternate 0,1,0,1
    b2.addr = {32'hC, 32'hC}; b2.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("rr_setup_paddr", b2.paddr, 32'hC);
      tick; tick;
      chk("rr_ack",   32'(b2.ack), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_rdata", b2.rdata, 32'h0000_C350);
      if (k == 3) b2.req = 2'b00;
      tick;
      chk("rr_gap_ack", 32'(b2.ack), 32'h0);
    end

    // req1 reads 0x18 (index 6): immediate error, no APB activity
    b2.addr[63:32] = 32'h18; b2.req = 2'b10;
    tick;
    chk("ill_ack",     32'(b2.ack), 32'h2);
    chk("ill_err",     32'(b2.err), 32'h1);
    chk("ill_rdata",   b2.rdata, 32'h0);
    chk("ill_penable", 32'(b2.penable), 32'h0);
    b2.req = 2'b00;
    tick;
    chk("ill_idle_ack",     32'(b2.ack), 32'h0);
    chk("ill_idle_penable", 32'(b2.penable), 32'h0);

    // following legal read by req0 proceeds normally
    b2.addr[31:0] = 32'h4; b2.req = 2'b01;
    tick;
    chk("post_setup_paddr",   b2.paddr, 32'h4);
    chk("post_setup_penable", 32'(b2.penable), 32'h0);
    tick;
    chk("post_access_penable", 32'(b2.penable), 32'h1);
    tick;
    chk("post_ack",   32'(b2.ack), 32'h1);
    chk("post_err",   32'(b2.err), 32'h0);
    chk("post_rdata", b2.rdata, 32'h1000);
    b2.req = 2'b00;
    tick;

    // address change during SETUP does not affect the transfer
    b2.addr[31:0] = 32'h8; b2.req = 2'b01;
    tick;
    chk("hold_setup_paddr", b2.paddr, 32'h8);
    b2.addr[31:0] = 32'h10;
    tick;
    chk("hold_access_paddr",   b2.paddr, 32'h8);
    chk("hold_access_penable", 32'(b2.penable), 32'h1);
    tick;
    chk("hold_ack",   32'(b2.ack), 32'h1);
    chk("hold_rdata", b2.rdata, 32'h2222_0002);
    b2.req = 2'b00;
    tick;

    // reset during ACCESS of a write to 0x00
    b2.we = 2'b01; b2.addr[31:0] = 32'h0; b2.wdata[31:0] = 32'hDEAD_BEEF; b2.req = 2'b01;
    tick;
    chk("mid_setup_pwrite", 32'(b2.pwrite), 32'h1);
    tick;
    chk("mid_access_penable", 32'(b2.penable), 32'h1);
    rst_n = 1'b0;
    tick;
    chk("mid_rst_ack",     32'(b2.ack), 32'h0);
    chk("mid_rst_penable", 32'(b2.penable), 32'h0);
    chk("mid_rst_pwrite",  32'(b2.pwrite), 32'h0);
    chk("mid_rst_paddr",   b2.paddr, 32'h0);
    chk("mid_rst_pwdata",  b2.pwdata, 32'h0);
    chk("mid_rst_rdata",   b2.rdata, 32'h0);
    chk("mid_rst_err",     32'(b2.err), 32'h0);
    rst_n = 1'b1;
    b2.addr[63:32] = 32'h0; b2.req = 2'b11;
    tick;
    chk("re_setup_paddr",  b2.paddr, 32'h0);
    chk("re_setup_pwrite", 32'(b2.pwrite), 32'h1);
    chk("re_setup_pwdata", b2.pwdata, 32'hDEAD_BEEF);
    tick; tick;
    chk("re_ack", 32'(b2.ack), 32'h1);
    chk("re_err", 32'(b2.err), 32'h0);
    b2.req = 2'b10;
    tick; tick;
    chk("re_rd_setup_pwrite", 32'(b2.pwrite), 32'h0);
    tick; tick;
    chk("re_rd_ack",   32'(b2.ack), 32'h2);
    chk("re_rd_rdata", b2.rdata, 32'hDEAD_BEEF);
    b2.req = 2'b00;
    tick;

    // 4 requesters: req2 alone sets last=2, then 0,2,3 active -> 3,0,2,3,0,2
    b4.addr = {32'hC, 32'h8, 32'h4, 32'h0}; b4.req = 4'b0100;
    tick; tick; tick;
    chk("rr4_pre_ack",   32'(b4.ack), 32'h4);
    chk("rr4_pre_rdata", b4.rdata, 32'hA000_0008);
    b4.req = 4'b1101;
    tick;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("rr4_setup_paddr", b4.paddr, 32'(order[k] * 4));
      tick; tick;
      chk("rr4_ack",   32'(b4.ack), 32'(1 << order[k]));
      chk("rr4_rdata", b4.rdata, 32'hA000_0000 | 32'(order[k] * 4));
      if (k == 5) b4.req = 4'b0000;
      tick;
      chk("rr4_gap_ack", 32'(b4.ack), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
